// File: rtl/store_unit.sv
// ---------------------------------------------------------------------------
// store_unit
//   Register-to-memory store path for sw/sh/sb. Word stores are written
//   directly; half-word and byte stores read the containing word, merge the
//   new lane(s) in and write the whole word back. Misaligned stores and the
//   reserved size raise a one-cycle exception without touching memory.
//
// Parameters
//   READ_LATENCY  cycles from mem_addr presented (mem_wr=0) to mem_rdata valid (1..7)
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   start       in   request pulse, sampled only when idle
//   store_size  in   00=word, 01=half, 10=byte, 11=reserved
//   addr        in   effective byte address
//   store_data  in   rt value (half uses [15:0], byte uses [7:0])
//   mem_rdata   in   data memory read data
//   mem_addr    out  word-aligned memory address
//   mem_wr      out  memory write enable, one cycle per store
//   mem_wdata   out  memory write data (registered)
//   busy        out  high whenever the unit is not idle
//   done        out  one-cycle pulse: store committed
//   exc         out  one-cycle pulse: misaligned or reserved size, no write
// ---------------------------------------------------------------------------
module store_unit #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_size,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        exc
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    DONE,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  localparam logic [2:0] RL = 3'(READ_LATENCY);

  state_t      state;
  size_t       size_q;
  logic [1:0]  lane_q;   // addr_q[1:0]; upper address bits live in mem_addr
  logic [15:0] data_q;   // only the low half is ever merged
  logic [2:0]  cnt;
  logic        bad_req;

  // Alignment / size legality of the request presented this cycle.
  always_comb begin
    bad_req = 1'b0;
    unique case (size_t'(store_size))
      SZ_WORD: bad_req = (addr[1:0] != 2'b00);
      SZ_HALF: bad_req = addr[0];
      SZ_BYTE: bad_req = 1'b0;
      SZ_RSVD: bad_req = 1'b1;
      default: bad_req = 1'b1;
    endcase
  end

  // Replace the addressed lane of the read word with the new data.
  function automatic logic [31:0] merge_lane(input logic [31:0] rd,
                                             input logic [15:0] d,
                                             input logic [1:0]  lane,
                                             input size_t       sz);
    logic [31:0] w;
    w = rd;
    if (sz == SZ_HALF) begin
      if (lane[1]) w[31:16] = d;
      else         w[15:0]  = d;
    end else begin
      unique case (lane)
        2'd0: w[7:0]   = d[7:0];
        2'd1: w[15:8]  = d[7:0];
        2'd2: w[23:16] = d[7:0];
        2'd3: w[31:24] = d[7:0];
        default: w = rd;
      endcase
    end
    return w;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      size_q    <= SZ_WORD;
      lane_q    <= '0;
      data_q    <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      exc       <= 1'b0;
    end else begin
      mem_wr <= 1'b0;
      done   <= 1'b0;
      exc    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            size_q   <= size_t'(store_size);
            lane_q   <= addr[1:0];
            data_q   <= store_data[15:0];
            mem_addr <= {addr[31:2], 2'b00};
            busy     <= 1'b1;
            if (bad_req) begin
              state <= ERR;
              exc   <= 1'b1;
            end else if (size_t'(store_size) == SZ_WORD) begin
              // Word stores need no read: the write is issued on the next cycle.
              state     <= WRITE;
              mem_wr    <= 1'b1;
              mem_wdata <= store_data;
            end else begin
              state <= READ;
              cnt   <= 3'd1;
            end
          end
        end
        READ: begin
          if (cnt == RL) state <= MERGE;
          else           cnt   <= cnt + 3'd1;
        end
        MERGE: begin
          // The read word is merged as it is captured, so the write data is
          // already registered when the WRITE cycle begins.
          mem_wdata <= merge_lane(mem_rdata, data_q, lane_q, size_q);
          mem_wr    <= 1'b1;
          state     <= WRITE;
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// ---------------------------------------------------------------------------
// tb_store_unit
//   Two store_unit instances (READ_LATENCY 1 and 3) share the same request
//   inputs and a common word memory image. Each instance gets its own read
//   pipeline returning junk until the read latency has elapsed.
// ---------------------------------------------------------------------------
module tb_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  store_size;
  logic [31:0] addr;
  logic [31:0] store_data;

  logic [31:0] mem_rdata [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic        mem_wr    [2];
  logic        busy      [2];
  logic        done      [2];
  logic        exc       [2];

  logic [31:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  int          wr_n   [2];
  int          done_n [2];
  int          exc_n  [2];
  int          wr_cyc   [2][4];
  int          done_cyc [2][4];
  int          exc_cyc  [2][4];
  logic [31:0] wr_addr  [2][4];
  logic [31:0] wr_data  [2][4];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int unsigned RL = (k == 0) ? 1 : 3;
    logic [31:0] pipe [RL];

    always @(posedge clk) begin
      pipe[0] <= busy[k] ? mem[mem_addr[k][9:2]] : $urandom;
      for (int i = 1; i < int'(RL); i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[k] = pipe[RL-1];

    store_unit #(.READ_LATENCY(RL)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .store_size (store_size),
      .addr       (addr),
      .store_data (store_data),
      .mem_rdata  (mem_rdata[k]),
      .mem_addr   (mem_addr[k]),
      .mem_wr     (mem_wr[k]),
      .mem_wdata  (mem_wdata[k]),
      .busy       (busy[k]),
      .done       (done[k]),
      .exc        (exc[k])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic clear_obs();
    for (int k = 0; k < 2; k++) begin
      wr_n[k] = 0; done_n[k] = 0; exc_n[k] = 0;
      for (int i = 0; i < 4; i++) begin
        wr_cyc[k][i] = -1; done_cyc[k][i] = -1; exc_cyc[k][i] = -1;
        wr_addr[k][i] = '0; wr_data[k][i] = '0;
      end
    end
  endtask

  task automatic observe(input int c);
    for (int k = 0; k < 2; k++) begin
      if (mem_wr[k] === 1'b1) begin
        if (wr_n[k] < 4) begin
          wr_cyc[k][wr_n[k]]  = c;
          wr_addr[k][wr_n[k]] = mem_addr[k];
          wr_data[k][wr_n[k]] = mem_wdata[k];
        end
        wr_n[k]++;
      end
      if (done[k] === 1'b1) begin
        if (done_n[k] < 4) done_cyc[k][done_n[k]] = c;
        done_n[k]++;
      end
      if (exc[k] === 1'b1) begin
        if (exc_n[k] < 4) exc_cyc[k][exc_n[k]] = c;
        exc_n[k]++;
      end
    end
  endtask

  // One store request: drive, observe 14 cycles, compare with the model.
  task automatic test_store(input string name, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d,
                            input bit mess);
    logic [31:0] old, expw;
    int          sh;
    bit          legal;
    bit          word;
    int          lat;
    old   = mem[a[9:2]];
    legal = !((sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b00 && a[1:0] != 2'b00));
    word  = (sz == 2'b00);
    expw  = d;
    if (sz == 2'b01) begin
      sh   = 16 * int'(a[1]);
      expw = (old & ~(32'h0000FFFF << sh)) | ((d & 32'h0000FFFF) << sh);
    end else if (sz == 2'b10) begin
      sh   = 8 * int'(a[1:0]);
      expw = (old & ~(32'h000000FF << sh)) | ((d & 32'h000000FF) << sh);
    end
    clear_obs();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      observe(c);
      if (c == 0) begin
        start = 1'b1; store_size = sz; addr = a; store_data = d;
      end else if (c == 2 && mess && legal) begin
        start = 1'b1; store_size = 2'($urandom); addr = $urandom; store_data = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      lat = lat_of(k);
      if (legal) begin
        n_cmp++;
        if (wr_n[k] !== 1) begin
          n_err++; $display("FAIL %s wr_count[RL=%0d]: got %0d expected 1", name, lat, wr_n[k]);
        end
        n_cmp++;
        if (wr_cyc[k][0] !== (word ? 1 : 2 + lat)) begin
          n_err++; $display("FAIL %s wr_cycle[RL=%0d]: got %0d expected %0d", name, lat, wr_cyc[k][0], word ? 1 : 2 + lat);
        end
        n_cmp++;
        if (wr_addr[k][0] !== {a[31:2], 2'b00}) begin
          n_err++; $display("FAIL %s mem_addr[RL=%0d]: got %h expected %h", name, lat, wr_addr[k][0], {a[31:2], 2'b00});
        end
        n_cmp++;
        if (wr_data[k][0] !== expw) begin
          n_err++; $display("FAIL %s mem_wdata[RL=%0d]: got %h expected %h", name, lat, wr_data[k][0], expw);
        end
        n_cmp++;
        if (done_n[k] !== 1 || done_cyc[k][0] !== (word ? 2 : 3 + lat)) begin
          n_err++; $display("FAIL %s done[RL=%0d]: got count %0d at cycle %0d expected 1 at %0d", name, lat, done_n[k], done_cyc[k][0], word ? 2 : 3 + lat);
        end
        n_cmp++;
        if (exc_n[k] !== 0) begin
          n_err++; $display("FAIL %s exc_count[RL=%0d]: got %0d expected 0", name, lat, exc_n[k]);
        end
      end else begin
        n_cmp++;
        if (exc_n[k] !== 1 || exc_cyc[k][0] !== 1) begin
          n_err++; $display("FAIL %s exc[RL=%0d]: got count %0d at cycle %0d expected 1 at 1", name, lat, exc_n[k], exc_cyc[k][0]);
        end
        n_cmp++;
        if (wr_n[k] !== 0 || done_n[k] !== 0) begin
          n_err++; $display("FAIL %s no_write[RL=%0d]: got wr %0d done %0d expected 0 0", name, lat, wr_n[k], done_n[k]);
        end
      end
    end
    if (legal) mem[a[9:2]] = expw;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; store_size = '0; addr = '0; store_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    #12;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (mem_addr[k] !== '0 || mem_wr[k] !== 1'b0 || mem_wdata[k] !== '0 ||
          busy[k] !== 1'b0 || done[k] !== 1'b0 || exc[k] !== 1'b0) begin
        n_err++; $display("FAIL reset_state[%0d]: got addr %h wr %b wdata %h busy %b done %b exc %b expected all 0",
                          k, mem_addr[k], mem_wr[k], mem_wdata[k], busy[k], done[k], exc[k]);
      end
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    test_store("word_0x100", 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_byte();
    logic [31:0] a [4];
    a[0] = 32'h106; a[1] = 32'h104; a[2] = 32'h105; a[3] = 32'h107;
    for (int i = 0; i < 4; i++) begin
      mem[32'h104 >> 2] = 32'h1122_3344;
      test_store("byte_lane", 2'b10, a[i], 32'hFFFF_FFAB, 1'b0);
    end
  endtask

  task automatic test_half();
    mem[32'h108 >> 2] = 32'hCAFE_BABE;
    test_store("half_upper", 2'b01, 32'h0000_010A, 32'h0000_1234, 1'b0);
    mem[32'h108 >> 2] = 32'hCAFE_BABE;
    test_store("half_lower", 2'b01, 32'h0000_0108, 32'h0000_1234, 1'b0);
  endtask

  task automatic test_misaligned();
    test_store("half_misaligned", 2'b01, 32'h0000_0101, 32'h1234_5678, 1'b0);
    test_store("word_misaligned", 2'b00, 32'h0000_0102, 32'h1234_5678, 1'b0);
    test_store("size_reserved",   2'b11, 32'h0000_0100, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_busy_ignored();
    test_store("busy_word", 2'b00, 32'h0000_0180, 32'hA5A5_0001, 1'b1);
    test_store("busy_byte", 2'b10, 32'h0000_0185, 32'h0000_00C3, 1'b1);
    test_store("busy_half", 2'b01, 32'h0000_018A, 32'h0000_7E57, 1'b1);
  endtask

  // ERR at cycle 1, word start in cycle 2, second word start right after DONE.
  task automatic test_back_to_back();
    clear_obs();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      observe(c);
      start = 1'b0;
      if (c == 0) begin start = 1'b1; store_size = 2'b11; addr = 32'h100; store_data = 32'h0; end
      if (c == 2) begin start = 1'b1; store_size = 2'b00; addr = 32'h200; store_data = 32'h0BAD_F00D; end
      if (c == 5) begin start = 1'b1; store_size = 2'b00; addr = 32'h204; store_data = 32'h1357_9BDF; end
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (exc_n[k] !== 1 || exc_cyc[k][0] !== 1) begin
        n_err++; $display("FAIL b2b_exc[%0d]: got count %0d at %0d expected 1 at 1", k, exc_n[k], exc_cyc[k][0]);
      end
      n_cmp++;
      if (wr_n[k] !== 2 || wr_cyc[k][0] !== 3 || wr_cyc[k][1] !== 6) begin
        n_err++; $display("FAIL b2b_wr_cycles[%0d]: got count %0d at %0d,%0d expected 2 at 3,6", k, wr_n[k], wr_cyc[k][0], wr_cyc[k][1]);
      end
      n_cmp++;
      if (wr_addr[k][0] !== 32'h200 || wr_data[k][0] !== 32'h0BAD_F00D ||
          wr_addr[k][1] !== 32'h204 || wr_data[k][1] !== 32'h1357_9BDF) begin
        n_err++; $display("FAIL b2b_wr_data[%0d]: got %h:%h %h:%h expected 00000200:0badf00d 00000204:13579bdf",
                          k, wr_addr[k][0], wr_data[k][0], wr_addr[k][1], wr_data[k][1]);
      end
      n_cmp++;
      if (done_n[k] !== 2 || done_cyc[k][0] !== 4 || done_cyc[k][1] !== 7) begin
        n_err++; $display("FAIL b2b_done[%0d]: got count %0d at %0d,%0d expected 2 at 4,7", k, done_n[k], done_cyc[k][0], done_cyc[k][1]);
      end
    end
    mem[32'h200 >> 2] = 32'h0BAD_F00D;
    mem[32'h204 >> 2] = 32'h1357_9BDF;
  endtask

  task automatic test_reset_midop();
    mem[32'h104 >> 2] = 32'h1122_3344;
    clear_obs();
    @(negedge clk); start = 1'b1; store_size = 2'b10; addr = 32'h106; store_data = 32'hFFFF_FFAB;
    @(negedge clk); start = 1'b0;
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (mem_addr[k] !== '0 || mem_wr[k] !== 1'b0 || mem_wdata[k] !== '0 ||
          busy[k] !== 1'b0 || done[k] !== 1'b0 || exc[k] !== 1'b0) begin
        n_err++; $display("FAIL reset_midop_outputs[%0d]: got addr %h wr %b wdata %h busy %b done %b exc %b expected all 0",
                          k, mem_addr[k], mem_wr[k], mem_wdata[k], busy[k], done[k], exc[k]);
      end
    end
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      observe(c);
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (wr_n[k] !== 0 || done_n[k] !== 0 || exc_n[k] !== 0) begin
        n_err++; $display("FAIL reset_midop_quiet[%0d]: got wr %0d done %0d exc %0d expected 0 0 0", k, wr_n[k], done_n[k], exc_n[k]);
      end
    end
    test_store("after_reset_byte", 2'b10, 32'h0000_0106, 32'hFFFF_FFAB, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b00) a[1:0] = 2'b00;
        if (sz == 2'b01) a[0]   = 1'b0;
      end
      test_store("random", sz, a, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_busy_ignored();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
